btn_report_tx: RTL and testbench
================================

Name: btn_report_tx

Overview:
Transmit side of the Pmod LED/button UART link on the 12 MHz iCE board. The block debounces the three Pmod buttons and serialises ASCII report frames on TX at 115200 baud, 8N1. Frame format mirrors the host-to-board LED command: 'B','0','0',<digit>,'\n'. A frame is sent whenever the debounced button state changes, or on request via QUERY.

Parameters:
CLK_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200).
DEBOUNCE_CYCLES, 12000, consecutive stable cycles needed to accept a new button level (1 ms).

Ports:
CLK  input  1  system clock, 12 MHz
RST  input  1  asynchronous reset, active-high
BTN1  input  1  raw button 1, asynchronous, high = pressed
BTN2  input  1  raw button 2
BTN3  input  1  raw button 3
QUERY  input  1  single-cycle pulse; requests a report of the current debounced state
TX  output  1  UART serial out, idle high
BUSY  output  1  high while a frame is being transmitted

Behaviour:
- Reset (asynchronous, active-high): TX=1, BUSY=0, debounced vector=000, pending=0, FSM=IDLE, all counters=0. Asserting RST mid-frame aborts the frame and forces TX high immediately. No frame is sent after reset unless a change or QUERY occurs.
- Synchroniser: each BTNn passes through a 2-flop synchroniser before debounce.
- Debounce, per button:
  - A counter increments while the synced level differs from the stable level. It clears whenever the two agree.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synced level and the counter clears.
  - mask = {BTN3,BTN2,BTN1} stable bits.
- Pending flag:
  - Set in any cycle where the mask changes or QUERY=1.
  - Cleared in the cycle the FSM leaves IDLE. Set has priority over clear in the same cycle.
  - Multiple events during a frame coalesce into one follow-up frame.
- Snapshot: the mask is latched when leaving IDLE. Digit = 0x30 + mask (0x30..0x37).
- Frame bytes, in order: 0x42, 0x30, 0x30, digit, 0x0A.
- FSM states:
  - IDLE: TX=1. If pending, go to START on the next edge.
  - START: TX=0 for CLK_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLK_PER_BIT cycles each.
  - STOP: TX=1 for CLK_PER_BIT cycles.
  - NEXT: one-cycle byte-index step. If index < 4, go to START with the next byte; otherwise go to IDLE.
- Each character is 10 bits. The NEXT cycle adds 1 clock between characters.
- Frame length = 5*(10*CLK_PER_BIT+1) cycles.
- BUSY is high in all states except IDLE.
- Latency: a pending flag seen in IDLE gives TX falling edge (start bit) 1 cycle later.
- After a frame, if pending is set, the next start bit follows after a single IDLE cycle.
- Button change to frame start: 2 (sync) + DEBOUNCE_CYCLES + 1 + 1 cycles.
- Glitch shorter than DEBOUNCE_CYCLES: no state change, no frame.
- QUERY while BUSY: sets pending; exactly one extra frame follows.

Test Plan:
- Use DEBOUNCE_CYCLES=16, CLK_PER_BIT=104. Decode TX with a bench UART receiver that samples at bit centres.
- Idle after reset, no stimulus for 20000 cycles -> TX stays 1, BUSY stays 0.
- BTN1 set to 1 and held -> exactly one frame "B001\n" (0x42,0x30,0x30,0x31,0x0A). BUSY high for 5205 cycles, then 0.
- BTN1=1 then BTN2=1 while the first frame is in flight, and QUERY pulsed during it -> frames "B001\n" then "B003\n" only. The second start bit appears 1 idle cycle after the first frame's final stop bit.
- BTN3 pulse of 10 cycles -> no frame. BTN3 held 40 cycles then released -> "B004\n" followed by "B000\n".
- QUERY pulse with all buttons at 0 in IDLE -> "B000\n"; TX falls exactly 1 cycle after the QUERY edge is registered.
- RST asserted during bit 3 of byte 2 -> TX=1 and BUSY=0 the same cycle. After release, no frame is sent until a new change or QUERY.

Source files
------------

// File: rtl/btn_report_tx.sv
// -----------------------------------------------------------------------------
// btn_report_tx
//
// Transmit side of the Pmod LED/button UART link. Debounces the three Pmod
// buttons and sends an ASCII report frame "B00<d>\n" at 8N1 whenever the
// debounced button state changes or a report is requested via QUERY.
// <d> is '0'..'7' = 0x30 + {BTN3,BTN2,BTN1}.
//
// Ports:
//   CLK    in   system clock (12 MHz)
//   RST    in   asynchronous reset, active-high
//   BTN1   in   raw button 1, asynchronous, high = pressed
//   BTN2   in   raw button 2
//   BTN3   in   raw button 3
//   QUERY  in   single-cycle pulse, requests a report of the current state
//   TX     out  UART serial out, idle high
//   BUSY   out  high while a frame is being transmitted
// -----------------------------------------------------------------------------
module btn_report_tx #(
  parameter int CLK_PER_BIT     = 104,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN1,
  input  logic BTN2,
  input  logic BTN3,
  input  logic QUERY,
  output logic TX,
  output logic BUSY
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW  = $clog2(CLK_PER_BIT + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     stable;          // debounced mask {BTN3,BTN2,BTN1}
  logic [DBW-1:0] db_cnt [3];

  // NOTE: the counter array is reset like any other register so the
  // debounce starts from a known zero count after RST, not from power-up junk.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage
      // pipeline; blocking here would collapse both flops into one.
      sync1 <= {BTN3, BTN2, BTN1};
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != stable[i]) begin
          // Counting the DEBOUNCE_CYCLES-th disagreeing cycle accepts the level.
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame byte selection
  // ---------------------------------------------------------------------------
  logic [2:0] snap;        // mask latched when a frame starts
  logic [2:0] byte_idx;    // 0..4 within the frame
  logic [7:0] cur_byte;

  // NOTE: cur_byte gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = 8'h42;            // 'B'
      3'd1:    cur_byte = 8'h30;            // '0'
      3'd2:    cur_byte = 8'h30;            // '0'
      3'd3:    cur_byte = {5'b00110, snap}; // 0x30 + mask
      default: cur_byte = 8'h0A;            // '\n'
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending flag and UART transmit FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  logic          pending;
  logic [2:0]    mask_q;   // previous debounced mask, for change detection
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      pending  <= 1'b0;
      mask_q   <= '0;
      snap     <= '0;
      byte_idx <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      TX       <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      mask_q <= stable;

      // A new event wins over the clear caused by leaving IDLE, so an event
      // in that exact cycle still produces a follow-up frame.
      if (stable != mask_q || QUERY) begin
        pending <= 1'b1;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          TX   <= 1'b1;
          BUSY <= 1'b0;
          if (pending) begin
            state    <= START;
            snap     <= stable;
            byte_idx <= '0;
            baud     <= '0;
            TX       <= 1'b0;
            BUSY     <= 1'b1;
          end
        end

        START: begin
          if (baud == BAUD_LAST) begin
            state   <= DATA;
            baud    <= '0;
            bit_idx <= '0;
            TX      <= cur_byte[0];
            shreg   <= {1'b0, cur_byte[7:1]};
          end else begin
            baud <= baud + BW'(1);
          end
        end

        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TX      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end

        STOP: begin
          if (baud == BAUD_LAST) begin
            state <= NEXT;
            baud  <= '0;
          end else begin
            baud <= baud + BW'(1);
          end
        end

        NEXT: begin
          // One extra clock between characters while the byte index steps.
          if (byte_idx < 3'd4) begin
            state    <= START;
            byte_idx <= byte_idx + 3'd1;
            TX       <= 1'b0;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_report_tx.sv
// -----------------------------------------------------------------------------
// tb_btn_report_tx
//
// Directed bench for btn_report_tx with DEBOUNCE_CYCLES=16, CLK_PER_BIT=104.
// A background UART receiver decodes TX at bit centres into a byte queue;
// the main sequence drives buttons/QUERY/RST and compares decoded frames,
// BUSY timing and reset behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_btn_report_tx;

  localparam int CPB   = 104;
  localparam int DEB   = 16;
  localparam int FRAME = 5 * (10 * CPB + 1);   // 5205

  logic CLK;
  logic RST;
  logic BTN1, BTN2, BTN3;
  logic QUERY;
  logic TX;
  logic BUSY;

  int tests = 0;
  int fails = 0;

  logic [7:0] rxq[$];
  int         rst_count = 0;

  btn_report_tx #(
    .CLK_PER_BIT     (CPB),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN1  (BTN1),
    .BTN2  (BTN2),
    .BTN3  (BTN3),
    .QUERY (QUERY),
    .TX    (TX),
    .BUSY  (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge RST) rst_count++;

  // Bench UART receiver: samples at bit centres, drops bytes cut by a reset.
  initial begin : uart_rx
    int         rc;
    logic [7:0] rx_byte;
    forever begin
      @(negedge TX);
      if (RST !== 1'b1) begin
        rc = rst_count;
        repeat (CPB / 2) @(negedge CLK);
        if (TX === 1'b0) begin
          for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge CLK);
            rx_byte[b] = TX;
          end
          repeat (CPB) @(negedge CLK);
          if (TX === 1'b1 && rst_count == rc && RST === 1'b0)
            rxq.push_back(rx_byte);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string tag);
    int n = 0;
    while (BUSY !== lvl && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check(tag, BUSY, lvl);
  endtask

  task automatic expect_frame(input logic [7:0] digit, input string tag);
    logic [7:0] exp_b [5];
    logic [7:0] got;
    int         n = 0;
    exp_b = '{8'h42, 8'h30, 8'h30, digit, 8'h0A};
    while (rxq.size() < 5 && n < 8000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_nbytes"}, 32'(rxq.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), got, exp_b[i]);
    end
    wait_busy(1'b0, 300, {tag, "_done"});
  endtask

  task automatic expect_quiet(input int n, input string tag);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      if (BUSY !== 1'b0) seen = 1'b1;
    end
    check({tag, "_busy"}, seen, 0);
    check({tag, "_rx"}, rxq.size(), 0);
  endtask

  initial begin : stim
    int bad;
    int len;
    int gap;
    int n;

    RST   = 1'b1;
    BTN1  = 1'b0;
    BTN2  = 1'b0;
    BTN3  = 1'b0;
    QUERY = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx", TX, 1);
    check("reset_busy", BUSY, 0);
    RST = 1'b0;

    // Idle after reset: nothing may be sent.
    bad = 0;
    repeat (20000) begin
      @(negedge CLK);
      if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check("idle_rx_empty", rxq.size(), 0);

    // BTN1 press: one frame "B001\n", BUSY high for exactly one frame.
    BTN1 = 1'b1;
    wait_busy(1'b1, 200, "t2_start");
    len = 0;
    while (BUSY === 1'b1 && len < FRAME + 100) begin
      len++;
      @(negedge CLK);
    end
    check("t2_busy_len", len, FRAME);
    expect_frame(8'h31, "t2");
    expect_quiet(300, "t2_quiet");

    // Back to 000 before the coalescing test.
    BTN1 = 1'b0;
    expect_frame(8'h30, "t3_pre");
    expect_quiet(300, "t3_pre_quiet");

    // BTN1 press, then BTN2 and QUERY during the frame: one follow-up frame.
    BTN1 = 1'b1;
    wait_busy(1'b1, 200, "t3_start");
    repeat (500) @(negedge CLK);
    BTN2 = 1'b1;
    repeat (100) @(negedge CLK);
    QUERY = 1'b1;
    @(negedge CLK);
    QUERY = 1'b0;
    wait_busy(1'b0, FRAME, "t3_end1");
    gap = 0;
    while (BUSY === 1'b0 && gap < 50) begin
      gap++;
      @(negedge CLK);
    end
    check("t3_idle_gap", gap, 1);
    wait_busy(1'b0, FRAME, "t3_end2");
    expect_frame(8'h31, "t3_f1");
    expect_frame(8'h33, "t3_f2");
    expect_quiet(2000, "t3_quiet");

    // Release both together: single change to 000.
    BTN1 = 1'b0;
    BTN2 = 1'b0;
    expect_frame(8'h30, "t4_pre");
    expect_quiet(300, "t4_pre_quiet");

    // Glitch shorter than the debounce window is ignored.
    BTN3 = 1'b1;
    repeat (10) @(negedge CLK);
    BTN3 = 1'b0;
    expect_quiet(300, "t4_glitch");

    // 40-cycle press: press frame, release coalesced into one follow-up.
    BTN3 = 1'b1;
    repeat (40) @(negedge CLK);
    BTN3 = 1'b0;
    expect_frame(8'h34, "t4_press");
    expect_frame(8'h30, "t4_release");
    expect_quiet(300, "t4_quiet");

    // QUERY in IDLE: TX falls one cycle after QUERY is registered.
    @(negedge CLK);
    QUERY = 1'b1;
    @(negedge CLK);
    QUERY = 1'b0;
    check("t5_tx_pending", TX, 1);
    @(negedge CLK);
    check("t5_tx_fall", TX, 0);
    check("t5_busy", BUSY, 1);
    expect_frame(8'h30, "t5");
    expect_quiet(200, "t5_quiet");

    // Reset during bit 3 of byte 2 aborts the frame immediately.
    QUERY = 1'b1;
    @(negedge CLK);
    QUERY = 1'b0;
    n = 0;
    while (TX !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t6_start", TX, 0);
    repeat (2 * (10 * CPB + 1) + 4 * CPB + CPB / 2) @(negedge CLK);
    check("t6_partial_bytes", rxq.size(), 2);
    #2 RST = 1'b1;
    #1;
    check("t6_rst_tx", TX, 1);
    check("t6_rst_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    rxq.delete();
    expect_quiet(3000, "t6_after");
    check("t6_after_tx", TX, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
